idp_radix_splitter_11: RTL and testbench

Upstream feeder for the 11-TSV IDP encoder stage: accepts 32-bit binary words and emits them as a stream of base-10000 digits, each in the range 0..9999, which is the legal input alphabet of the 11-TSV encoder. Conversion uses a bit-serial restoring divider, one quotient bit per clock. The output side uses a valid/ready handshake, so the encoder clock domain can stall it. Every input word produces exactly NDIG digits, least-significant digit first, with the last digit flagged.

---
 rtl/idp_radix_splitter_11_if.sv | 38 +++
 rtl/idp_radix_splitter_11.sv | 133 +++++++++++++
 tb/tb_idp_radix_splitter_11.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/idp_radix_splitter_11_if.sv
// idp_radix_splitter_11_if
//   Bundles the word-input and digit-output handshakes of the radix splitter.
//
//   Handshake rule for both channels: a transfer happens on a rising clock edge
//   where valid and ready are both high. The producer holds valid and its
//   payload stable until that edge. The consumer may raise or lower ready at
//   any time. valid never depends combinationally on ready.
//
//   Signals:
//     in_valid / in_ready / in_data          : binary word channel (into block)
//     out_valid / out_ready / out_digit /
//     out_idx / out_last                     : base-RADIX digit channel (out of block)
//   Modports:
//     master : the environment side (drives words, accepts digits)
//     slave  : the splitter side
interface idp_radix_splitter_11_if #(
  parameter int IN_W  = 32,
  parameter int DIG_W = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DIG_W-1:0] out_digit;
  logic [1:0]       out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_digit, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_digit, out_idx, out_last
  );
endinterface

// File: rtl/idp_radix_splitter_11.sv
// idp_radix_splitter_11
//   Converts 32-bit binary words into NDIG base-RADIX digits, least significant
//   digit first, for the 11-TSV IDP encoder. Each digit comes from a bit-serial
//   restoring division of the running quotient by RADIX. One quotient bit is
//   produced per clock. The remainder is the digit, and the quotient is kept
//   for the next digit.
//
//   Ports:
//     clock     : rising-edge clock
//     reset     : synchronous, active-high
//     bus       : slave side of idp_radix_splitter_11_if (word in, digit out)
//     dbg_state : current FSM state (0 IDLE, 1 DIV, 2 EMIT)
//
//   All outputs are decoded from registered state only. in_valid and out_ready
//   never reach an output combinationally.
module idp_radix_splitter_11 #(
  parameter int IN_W  = 32,
  parameter int DIG_W = 14,
  parameter int RADIX = 10000,
  parameter int NDIG  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  idp_radix_splitter_11_if.slave bus,
  output logic [1:0]            dbg_state
);

  function automatic longint unsigned ipow(input longint unsigned b, input int e);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // NDIG digits must be able to represent every IN_W-bit word.
  if (ipow(longint'(RADIX), NDIG) < (64'd1 << IN_W)) begin : g_bad_radix
    $error("idp_radix_splitter_11: RADIX**NDIG < 2**IN_W");
  end

  localparam int BCW = $clog2(IN_W);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(IN_W - 1);
  localparam logic [1:0]       LAST_IDX = 2'(NDIG - 1);
  localparam logic [DIG_W+1:0] RADIX_T  = (DIG_W + 2)'(RADIX);
  localparam logic [DIG_W:0]   RADIX_R  = (DIG_W + 1)'(RADIX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [IN_W-1:0]  acc;     // dividend, becomes the quotient as bits shift in
  logic [DIG_W:0]   rem;     // partial remainder, always < RADIX between steps
  logic [1:0]       idx;     // digit being produced
  logic [BCW-1:0]   bitcnt;  // division step within the current digit

  logic [DIG_W+1:0] t;
  logic             qbit;
  logic [DIG_W:0]   diff;
  logic [DIG_W:0]   rem_nx;
  logic             is_last;

  // One restoring-division step. rem < RADIX, so t < 2*RADIX. The subtraction
  // therefore fits in rem's width whenever it is taken.
  always_comb begin
    t      = {rem, acc[IN_W-1]};
    qbit   = (t >= RADIX_T);
    diff   = t[DIG_W:0] - RADIX_R;
    rem_nx = qbit ? diff : t[DIG_W:0];
  end

  assign is_last = (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.in_valid)        state_nx = S_DIV;
      S_DIV:   if (bitcnt == LAST_BIT)  state_nx = S_EMIT;
      S_EMIT:  if (bus.out_ready)       state_nx = is_last ? S_IDLE : S_DIV;
      default:                          state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc    <= '0;
      rem    <= '0;
      idx    <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            acc    <= bus.in_data;
            rem    <= '0;
            idx    <= '0;
            bitcnt <= '0;
          end
        end
        S_DIV: begin
          acc    <= {acc[IN_W-2:0], qbit};
          rem    <= rem_nx;
          bitcnt <= bitcnt + BCW'(1);
        end
        S_EMIT: begin
          // acc already holds the quotient, which is the dividend for the next digit.
          if (bus.out_ready && !is_last) begin
            idx    <= idx + 2'd1;
            rem    <= '0;
            bitcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload is zeroed outside EMIT so that idle outputs are clean.
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_EMIT);
  assign bus.out_digit = (state == S_EMIT) ? rem[DIG_W-1:0] : '0;
  assign bus.out_idx   = (state == S_EMIT) ? idx : 2'd0;
  assign bus.out_last  = (state == S_EMIT) && is_last;
  assign dbg_state     = state;

endmodule

// File: tb/tb_idp_radix_splitter_11.sv
// Testbench for idp_radix_splitter_11: directed scenarios plus randomized words
// checked against an arithmetic digit model held in an expected queue.
module tb_idp_radix_splitter_11;
  localparam int IN_W  = 32;
  localparam int DIG_W = 14;
  localparam int RADIX = 10000;
  localparam int NDIG  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [DIG_W-1:0] exp_q[$];

  idp_radix_splitter_11_if #(.IN_W(IN_W), .DIG_W(DIG_W)) bus ();

  idp_radix_splitter_11 #(.IN_W(IN_W), .DIG_W(DIG_W), .RADIX(RADIX), .NDIG(NDIG)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_push(input logic [IN_W-1:0] v);
    longint unsigned x;
    x = longint'(v);
    for (int i = 0; i < NDIG; i++) begin
      exp_q.push_back(DIG_W'(x % RADIX));
      x = x / RADIX;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [IN_W-1:0] d, output bit ok, output int unsigned acc_cyc);
    ok = 1'b0;
    acc_cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 300; n++) begin
      if (bus.in_ready) begin
        step();
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_digit(input int stall, output logic [DIG_W-1:0] digit,
                            output logic [1:0] idx, output logic last,
                            output int lat, output bit ok, output bit stable);
    bus.out_ready = 1'b0;
    lat = 0; ok = 1'b0; stable = 1'b1;
    digit = '0; idx = '0; last = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      step();
      lat++;
    end
    if (bus.out_valid) begin
      ok = 1'b1;
      digit = bus.out_digit;
      idx   = bus.out_idx;
      last  = bus.out_last;
      for (int s = 0; s < stall; s++) begin
        step();
        if (bus.out_valid !== 1'b1 || bus.out_digit !== digit ||
            bus.out_idx !== idx || bus.out_last !== last) stable = 1'b0;
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_data = 32'd77; bus.out_ready = 1'b0;
    reset = 1'b1;
    step(); step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_digit !== '0) begin errors++; $display("FAIL reset_out_digit: got %0d expected 0", bus.out_digit); end
    checks++; if (bus.out_idx !== 2'd0) begin errors++; $display("FAIL reset_out_idx: got %0d expected 0", bus.out_idx); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b expected 0", bus.out_last); end
    reset = 1'b0; bus.in_valid = 1'b0;
    // A word offered during reset must not have been taken.
    for (int i = 0; i < 40; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_ignore_in: out_valid %0b in_ready %0b expected 0/1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_zero();
    bit ok, st; int lat; int unsigned ac;
    logic [DIG_W-1:0] d; logic [1:0] ix; logic lst;
    send_word(32'd0, ok, ac);
    checks++; if (!ok) begin errors++; $display("FAIL zero_accept: got timeout expected accept"); end
    for (int i = 0; i < NDIG; i++) begin
      recv_digit(0, d, ix, lst, lat, ok, st);
      checks++; if (!ok) begin errors++; $display("FAIL zero_valid: got timeout expected digit %0d", i); end
      checks++; if (d !== '0) begin errors++; $display("FAIL zero_digit: got %0d expected 0", d); end
      checks++; if (ix !== 2'(i)) begin errors++; $display("FAIL zero_idx: got %0d expected %0d", ix, i); end
      checks++; if (lst !== (i == NDIG-1)) begin errors++; $display("FAIL zero_last: got %0b expected %0b", lst, (i == NDIG-1)); end
    end
  endtask

  task automatic test_max();
    bit ok, st; int lat; int unsigned ac;
    logic [DIG_W-1:0] d; logic [1:0] ix; logic lst;
    logic [DIG_W-1:0] exp_d [NDIG];
    exp_d[0] = 14'd7295; exp_d[1] = 14'd9496; exp_d[2] = 14'd42;
    send_word(32'hFFFF_FFFF, ok, ac);
    checks++; if (!ok) begin errors++; $display("FAIL max_accept: got timeout expected accept"); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL max_busy: in_ready got %0b expected 0", bus.in_ready); end
    for (int i = 0; i < NDIG; i++) begin
      recv_digit(0, d, ix, lst, lat, ok, st);
      checks++; if (lat != IN_W) begin errors++; $display("FAIL max_latency: got %0d expected %0d", lat, IN_W); end
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL max_digit: got %0d expected %0d", d, exp_d[i]); end
      checks++; if (ix !== 2'(i)) begin errors++; $display("FAIL max_idx: got %0d expected %0d", ix, i); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL max_valid_drop: got %0b expected 0", bus.out_valid); end
    end
    checks++; if (cyc - ac != 99) begin errors++; $display("FAIL max_occupancy: got %0d expected 99", cyc - ac); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL max_ready_again: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_stall();
    bit ok, st; int lat; int unsigned ac;
    logic [DIG_W-1:0] d; logic [1:0] ix; logic lst;
    logic [DIG_W-1:0] exp_d [NDIG];
    exp_d[0] = 14'd6789; exp_d[1] = 14'd2345; exp_d[2] = 14'd1;
    send_word(32'd123456789, ok, ac);
    checks++; if (!ok) begin errors++; $display("FAIL stall_accept: got timeout expected accept"); end
    for (int i = 0; i < NDIG; i++) begin
      recv_digit(5, d, ix, lst, lat, ok, st);
      checks++; if (!st) begin errors++; $display("FAIL stall_stable: got changed outputs expected stable on digit %0d", i); end
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL stall_digit: got %0d expected %0d", d, exp_d[i]); end
      checks++; if (ix !== 2'(i)) begin errors++; $display("FAIL stall_idx: got %0d expected %0d", ix, i); end
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_no_extra: in_ready got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    bit ok, st; int lat;
    logic [DIG_W-1:0] d; logic [1:0] ix; logic lst;
    logic [DIG_W-1:0] exp_d [2*NDIG];
    exp_d[0] = 14'd9999; exp_d[1] = 14'd0; exp_d[2] = 14'd0;
    exp_d[3] = 14'd0;    exp_d[4] = 14'd1; exp_d[5] = 14'd0;
    bus.in_valid = 1'b1; bus.in_data = 32'd9999;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: in_ready got %0b expected 1", bus.in_ready); end
    step();
    bus.in_data = 32'd10000;
    for (int i = 0; i < NDIG; i++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: in_ready got %0b expected 0", bus.in_ready); end
      recv_digit(0, d, ix, lst, lat, ok, st);
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL b2b_digit_a: got %0d expected %0d", d, exp_d[i]); end
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b expected 1", bus.in_ready); end
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: in_ready got %0b expected 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      recv_digit(0, d, ix, lst, lat, ok, st);
      checks++; if (d !== exp_d[NDIG+i]) begin errors++; $display("FAIL b2b_digit_b: got %0d expected %0d", d, exp_d[NDIG+i]); end
      checks++; if (ix !== 2'(i)) begin errors++; $display("FAIL b2b_idx: got %0d expected %0d", ix, i); end
    end
  endtask

  task automatic test_reset_mid_div();
    bit ok, st; int lat; int unsigned ac;
    logic [DIG_W-1:0] d; logic [1:0] ix; logic lst;
    send_word(32'hFFFF_FFFF, ok, ac);
    recv_digit(0, d, ix, lst, lat, ok, st);
    checks++; if (d !== 14'd7295) begin errors++; $display("FAIL rmid_digit0: got %0d expected 7295", d); end
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %0b expected 1", bus.in_ready); end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_digit: out_valid got %0b expected 0", bus.out_valid); end
    end
    send_word(32'd5, ok, ac);
    for (int i = 0; i < NDIG; i++) begin
      recv_digit(0, d, ix, lst, lat, ok, st);
      checks++; if (d !== ((i == 0) ? 14'd5 : 14'd0)) begin errors++; $display("FAIL rmid_new_word: got %0d expected %0d", d, (i == 0) ? 5 : 0); end
      checks++; if (ix !== 2'(i)) begin errors++; $display("FAIL rmid_idx: got %0d expected %0d", ix, i); end
    end
  endtask

  task automatic test_random();
    bit ok, st; int lat; int unsigned ac;
    logic [DIG_W-1:0] d, e; logic [1:0] ix; logic lst;
    logic [IN_W-1:0] v;
    logic [IN_W-1:0] corner [6];
    corner[0] = 32'd0;        corner[1] = 32'd9999;    corner[2] = 32'd10000;
    corner[3] = 32'd99999999; corner[4] = 32'd100000000; corner[5] = 32'hFFFF_FFFF;
    for (int w = 0; w < 150; w++) begin
      v = (w < 6) ? corner[w] : IN_W'($urandom);
      model_push(v);
      send_word(v, ok, ac);
      checks++; if (!ok) begin errors++; $display("FAIL rand_accept: got timeout expected accept of %0d", v); end
      for (int i = 0; i < NDIG; i++) begin
        recv_digit($urandom_range(0, 3), d, ix, lst, lat, ok, st);
        e = exp_q.pop_front();
        checks++; if (!ok || d !== e) begin errors++; $display("FAIL rand_digit: word %0d idx %0d got %0d expected %0d", v, i, d, e); end
        checks++; if (d >= DIG_W'(RADIX)) begin errors++; $display("FAIL rand_range: got %0d expected < %0d", d, RADIX); end
        checks++; if (ix !== 2'(i) || lst !== (i == NDIG-1)) begin errors++; $display("FAIL rand_idx_last: got %0d/%0b expected %0d/%0b", ix, lst, i, (i == NDIG-1)); end
        checks++; if (!st) begin errors++; $display("FAIL rand_stable: got changed outputs expected stable"); end
      end
      repeat ($urandom_range(0, 2)) step();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_queue: got %0d leftover expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_max();
    test_stall();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run always ends, even if the design deadlocks.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
